// File: rtl/regfile_w5_if.sv
// Writeback and operand-read bus of the register file: one write port, two combinational read ports.
interface regfile_w5_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [WIDTH-1:0]  rdata1;
  logic [WIDTH-1:0]  rdata2;

  modport master (
    output we, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile_w5.sv
// 32-entry register file: r0 hardwired to zero, synchronous write, two
// combinational read ports with write-first bypass from the writeback port.
module regfile_w5 #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  regfile_w5_if.slave  rf
);
  localparam int unsigned NREGS = 2 ** ADDR_W;

  // r0 has no storage; index 0 is resolved in the read logic.
  logic [WIDTH-1:0] regs [1:NREGS-1];

  // Storage update: reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        regs[ADDR_W'(i)] <= '0;
      end
    end else if (rf.we && (rf.waddr != '0)) begin
      regs[rf.waddr] <= rf.wdata;
    end
  end

  // Read port 1
  always_comb begin
    rf.rdata1 = '0;
    if (!rst && (rf.raddr1 != '0)) begin
      if (rf.we && (rf.raddr1 == rf.waddr)) begin
        rf.rdata1 = rf.wdata;
      end else begin
        rf.rdata1 = regs[rf.raddr1];
      end
    end
  end

  // Read port 2
  always_comb begin
    rf.rdata2 = '0;
    if (!rst && (rf.raddr2 != '0)) begin
      if (rf.we && (rf.raddr2 == rf.waddr)) begin
        rf.rdata2 = rf.wdata;
      end else begin
        rf.rdata2 = regs[rf.raddr2];
      end
    end
  end
endmodule
